// File: rtl/mem_req_bridge.sv
// Request-side front end for the 8-bit single-port memory: issues accepted
// transactions, tracks the one-cycle read latency and returns results through a credited FIFO.
module mem_req_bridge #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int ID_W      = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ID_W-1:0]   req_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    output logic              mem_wr_rdn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic              accept;
    logic              push;
    logic              pop;
    logic              s1_vld;
    logic              s1_wr;
    logic [ID_W-1:0]   s1_id;
    logic              s2_vld;
    logic              s2_wr;
    logic [ID_W-1:0]   s2_id;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W:0]    occ;

    logic              fifo_wr   [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic [ID_W-1:0]   fifo_id   [RSP_DEPTH];

    // Every in-flight transaction holds a FIFO slot, so a push can never overflow.
    assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_vld} + {{CNT_W{1'b0}}, s2_vld};
    assign req_ready = (occ < (CNT_W+1)'(RSP_DEPTH)) && !rst;
    assign accept    = req_valid && req_ready;
    assign push      = s2_vld;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_wr    = rsp_valid && fifo_wr[rd_ptr];
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_rdn <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            s1_vld     <= 1'b0;
            s1_wr      <= 1'b0;
            s1_id      <= '0;
            s2_vld     <= 1'b0;
            s2_wr      <= 1'b0;
            s2_id      <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            mem_wr_rdn <= accept && req_wr;
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            s1_vld <= accept;
            s1_wr  <= req_wr;
            s1_id  <= req_id;
            s2_vld <= s1_vld;
            s2_wr  <= s1_wr;
            s2_id  <= s1_id;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while fifo_count covers them.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_wr[wr_ptr]   <= s2_wr;
            fifo_data[wr_ptr] <= s2_wr ? '0 : mem_rdata;
            fifo_id[wr_ptr]   <= s2_id;
        end
    end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: memory model, transaction-level reference model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_mem_req_bridge;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_id;
    logic       rsp_valid, rsp_ready, rsp_wr;
    logic [7:0] rsp_data;
    logic [1:0] rsp_id;
    logic       mem_wr_rdn;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    always #5 clk = ~clk;

    mem_req_bridge #(.ADDR_W(4), .DATA_W(8), .ID_W(2), .RSP_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .mem_wr_rdn(mem_wr_rdn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory, registered read, cleared by reset.
    logic [7:0] mem_arr [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_wr_rdn) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle", name, act, exp);
        end
    endtask

    // Reference model: ordered list of outstanding transactions, each with the
    // cycle from which its response must be visible.
    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic [1:0] id;
        int         t;
    } ent_t;

    ent_t       q[$];
    ent_t       got[$];
    logic [7:0] shadow [16];
    int         cyc = 0;
    int         acc_cnt = 0;
    bit         acc_evt = 0;
    bit         exp_issue = 0;
    bit         exp_mw = 0;
    logic [3:0] exp_ma = 4'h0;
    logic [7:0] exp_md = 8'h00;
    bit         chk_en = 0;

    always @(posedge clk) begin
        bit   ok;
        ent_t e;
        ok      = (q.size() < D);
        acc_evt = 0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
            exp_issue = 0;
            exp_mw    = 0;
            exp_ma    = 4'h0;
            exp_md    = 8'h00;
        end else begin
            if (q.size() > 0 && q[0].t <= cyc && rsp_ready) void'(q.pop_front());
            exp_issue = 0;
            exp_mw    = 0;
            if (req_valid && ok) begin
                e.wr   = req_wr;
                e.data = req_wr ? 8'h00 : shadow[req_addr];
                e.id   = req_id;
                e.t    = cyc + 3;
                if (req_wr) shadow[req_addr] = req_wdata;
                q.push_back(e);
                exp_issue = 1;
                exp_mw    = req_wr;
                exp_ma    = req_addr;
                exp_md    = req_wdata;
                acc_evt   = 1;
                acc_cnt++;
            end
        end
        cyc++;
        chk_en = 1;
    end

    int ready_low_cnt = 0;
    int mw_cnt = 0;
    int rv_cnt = 0;

    always @(negedge clk) begin
        bit   ev;
        ent_t g;
        if (chk_en) begin
            ev = (q.size() > 0) && (q[0].t <= cyc);
            chk("req_ready", req_ready, !rst && (q.size() < D));
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_wr", rsp_wr, q[0].wr);
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_id", rsp_id, q[0].id);
            end
            chk("mem_wr_rdn", mem_wr_rdn, exp_mw);
            if (exp_issue) begin
                chk("mem_addr", mem_addr, exp_ma);
                if (exp_mw) chk("mem_wdata", mem_wdata, exp_md);
            end
            if (!req_ready && !rst) ready_low_cnt++;
            if (mem_wr_rdn) mw_cnt++;
            if (rsp_valid) rv_cnt++;
            if (rsp_valid && rsp_ready) begin
                g.wr = rsp_wr; g.data = rsp_data; g.id = rsp_id; g.t = cyc;
                got.push_back(g);
            end
        end
    end

    task automatic go(input bit wr, input logic [3:0] a, input logic [7:0] d, input logic [1:0] id);
        bit done;
        done      = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_id    = id;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            done = acc_evt;
        end
        if (!done) chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pack(input ent_t e);
        return {21'd0, e.wr, e.data, e.id};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int a0;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 4'h0;
        req_wdata = 8'h00; req_id = 2'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_wr, rsp_data, rsp_id}, 0);
        chk("rst_mem_out", {mem_wr_rdn, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);

        // Write then read.
        got.delete();
        go(1, 4'd3, 8'hA5, 2'd1);
        a0 = cyc;
        go(0, 4'd3, 8'h00, 2'd2);
        idle(4);
        chk("wr_rd_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("wr_rsp", pack(got[0]), {21'd0, 1'b1, 8'h00, 2'd1});
            chk("rd_rsp", pack(got[1]), {21'd0, 1'b0, 8'hA5, 2'd2});
            chk("wr_latency", got[0].t, a0 + 2);
            chk("rd_next_cycle", got[1].t, got[0].t + 1);
        end

        // Back-to-back streaming.
        got.delete();
        ready_low_cnt = 0;
        for (int i = 0; i < 4; i++) go(1, 4'(i), 8'(8'h10 + i), 2'(i));
        for (int i = 0; i < 4; i++) go(0, 4'(i), 8'h00, 2'(i));
        chk("stream_ready_low", ready_low_cnt, 0);
        idle(5);
        chk("stream_count", got.size(), 8);
        if (got.size() == 8) begin
            for (int i = 0; i < 4; i++) begin
                chk("stream_rd", pack(got[4+i]), {21'd0, 1'b0, 8'(8'h10 + i), 2'(i)});
                if (i > 0) chk("stream_consec", got[4+i].t, got[3+i].t + 1);
            end
        end

        // Backpressure: 6 reads offered, only 4 fit.
        got.delete();
        rsp_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) go(0, 4'(i), 8'h00, 2'(i));
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd0; req_id = 2'd0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", acc_cnt - a0, 4);
        chk("bp_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_before_pop", req_ready, 0);
        @(posedge clk);
        #1;
        chk("bp_ready_after_pop", req_ready, 1);
        go(0, 4'd0, 8'h00, 2'd0);
        go(0, 4'd1, 8'h00, 2'd1);
        idle(6);
        chk("bp_count", got.size(), 6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("bp_order", pack(got[i]), {21'd0, 1'b0, 8'(8'h10 + (i % 4)), 2'(i % 4)});
        end

        // Idle bus, then confirm memory untouched.
        mw_cnt = 0;
        rv_cnt = 0;
        idle(10);
        chk("idle_mem_wr", mw_cnt, 0);
        chk("idle_rsp_valid", rv_cnt, 0);
        got.delete();
        go(0, 4'd2, 8'h00, 2'd3);
        idle(4);
        chk("idle_readback", got.size() == 1 ? pack(got[0]) : 32'hDEAD, {21'd0, 1'b0, 8'h12, 2'd3});

        // Reset mid-flight.
        got.delete();
        go(0, 4'd2, 8'h00, 2'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        chk("mid_rst_no_rsp", got.size(), 0);
        go(0, 4'd2, 8'h00, 2'd1);
        idle(4);
        chk("post_rst_read", got.size() == 1 ? pack(got[0]) : 32'hDEAD, {21'd0, 1'b0, 8'h00, 2'd1});

        // Simultaneous push/pop with three responses queued, across pointer wraps.
        for (int i = 0; i < 8; i++) go(1, 4'(i), 8'(8'h30 + i), 2'(i));
        idle(4);
        got.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) go(0, 4'(i), 8'h00, 2'(i));
        idle(1);
        rsp_ready = 1'b1;
        for (int i = 4; i < 12; i++) go(0, 4'(i % 8), 8'h00, 2'(i % 4));
        idle(8);
        chk("wrap_count", got.size(), 12);
        if (got.size() == 12) begin
            for (int i = 0; i < 12; i++)
                chk("wrap_order", pack(got[i]), {21'd0, 1'b0, 8'(8'h30 + (i % 8)), 2'(i % 4)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_bridge.md
# mem_req_bridge

Request-side front end for the 8-bit single-port memory block, sitting directly upstream of it. Accepts read/write transactions on a valid/ready request channel and drives the memory's `wr_rdn`/`addr`/`in_data` port. It tracks the memory's one-cycle read latency through a two-stage tag pipeline and returns every transaction's result, reads and writes, on a valid/ready response channel. A credit-controlled response FIFO guarantees that a stalled consumer never loses data.

## Interface
- `ADDR_W`, 4: address width; matches the memory `addr` port.
- `DATA_W`, 8: data width; matches the memory `in_data`/`out_data`.
- `ID_W`, 2: transaction tag width; the tag is passed through unchanged.
- `RSP_DEPTH`, 4: response FIFO depth; power of 2, minimum 2, and at least 4 for full throughput.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge accepts the request this cycle.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data; ignored for reads.
- `req_id`  in  ID_W  transaction tag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_wr`  out  1  response belongs to a write.
- `rsp_data`  out  DATA_W  read data; 0 for writes.
- `rsp_id`  out  ID_W  tag of the original request.
- `mem_wr_rdn`  out  1  drives memory `wr_rdn`.
- `mem_addr`  out  ADDR_W  drives memory `addr`.
- `mem_wdata`  out  DATA_W  drives memory `in_data`.
- `mem_rdata`  in  DATA_W  from memory `out_data`.

## Operation
- **Accept.** A request is accepted on any rising edge where `req_valid && req_ready`.
- **Credit rule.** `occ = fifo_count + s1_vld + s2_vld`; `req_ready = (occ < RSP_DEPTH) && !rst`.
  - `req_ready` is combinational from registers only.
  - It never depends on `req_valid` or `rsp_ready`.
- **Issue (stage 1).** On the accept edge, register `mem_wr_rdn <= req_wr`, `mem_addr <= req_addr`, `mem_wdata <= req_wdata`, and `s1 <= {1, req_wr, req_id}`.
  - With no accept: `mem_wr_rdn <= 0`, `s1_vld <= 0`, and `mem_addr`/`mem_wdata` hold their values.
  - The bridge never issues a write without an accepted write request.
- **Stage 2.** `s2 <= s1` every edge, carrying tag and type only.
- **Capture.** When `s2_vld`, push `{s2_id, s2_wr, s2_wr ? 0 : mem_rdata}` into the response FIFO on that edge.
  - `mem_rdata` is ignored in every other cycle; the memory reads continuously while idle.
- **Response FIFO.**
  - Ordering: first-word-fall-through; `rsp_*` show the head entry.
  - `rsp_valid = (fifo_count != 0)`.
  - Pop on `rsp_valid && rsp_ready`.
  - Simultaneous push and pop leaves `fifo_count` unchanged; pointers wrap modulo `RSP_DEPTH`.
  - Overflow is impossible by the credit rule, so no push is ever dropped.
- **Ordering.** Responses leave strictly in acceptance order.
- **Reset.** While `rst` is high, including mid-transaction:
  - `s1_vld`, `s2_vld`, `fifo_count`, and the FIFO pointers go to 0.
  - In-flight transactions are discarded with no response.
  - `mem_wr_rdn = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Output reset values.** `req_ready = 0` during reset. `rsp_valid = 0`; `rsp_wr`, `rsp_data`, `rsp_id` = 0. Memory outputs = 0.

## Timing
- **Memory port.** Accept at edge E0 puts the memory signals valid during cycle E0–E1. The memory samples at E1 and `mem_rdata` is valid during E1–E2.
- **Response.** The FIFO push happens at E2. `rsp_valid` is high in the cycle after E2, giving 2 cycles from accept to response.
- **Throughput.** With `RSP_DEPTH >= 4` and `rsp_ready` tied high, one transaction per cycle is sustained (steady `occ` = 3).
- **Backpressure.** With `rsp_ready` low, at most `RSP_DEPTH` transactions are accepted. `req_ready` then falls and rises again on the edge after the first pop.
- **After reset.** `req_ready` may assert in the first cycle after `rst` deasserts.

## Test plan
- **Write then read.** Write addr 3 = 0xA5 (id 1), then read addr 3 (id 2), `rsp_ready=1`.
  - Expect `{wr=1, data=0x00, id=1}`, then `{wr=0, data=0xA5, id=2}` the next cycle.
  - Each response appears 2 cycles after its accept.
- **Back-to-back streaming.** Write addr 0–3 with 0x10–0x13, then 4 reads of addr 0–3 on consecutive cycles.
  - Expect `req_ready` constantly 1.
  - Expect read data 0x10–0x13 in order on 4 consecutive cycles.
- **Backpressure.** `rsp_ready=0`, 6 read requests offered.
  - Exactly 4 are accepted and `req_ready` drops to 0.
  - Raising `rsp_ready` drains 4 responses in order, then the remaining 2 are accepted and complete.
- **Idle bus.** 10 idle cycles.
  - `mem_wr_rdn` stays 0, `rsp_valid` stays 0, and memory contents are unchanged (checked by a later read).
- **Reset mid-flight.** Accept a read, assert `rst` for 1 cycle at E1.
  - No response is ever produced; `rsp_valid=0` and `req_ready=0` during reset.
  - A new read after reset returns 0x00 with the memory also reset.
- **Simultaneous push and pop at depth.** Fill the FIFO to 3, then pop and push in the same cycle.
  - `fifo_count` stays 3 and the wrapped pointers preserve order across 2 full wraps.
